// File: rtl/decoder_pkg.sv
// Shared constants for the instruction decoder: data widths, opcode map and
// the controller state encoding.
package decoder_pkg;

   localparam int unsigned DEC_BYTE     = 8;
   localparam int unsigned DEC_WIDTH_IN = 2 * DEC_BYTE;

   // Opcode map (upper byte of the instruction word)
   localparam logic [7:0] OP_NOP  = 8'h00;
   localparam logic [7:0] OP_LDI  = 8'h01;
   localparam logic [7:0] OP_ADD  = 8'h02;
   localparam logic [7:0] OP_SUB  = 8'h03;
   localparam logic [7:0] OP_AND  = 8'h04;
   localparam logic [7:0] OP_OR   = 8'h05;
   localparam logic [7:0] OP_XOR  = 8'h06;
   localparam logic [7:0] OP_SHL  = 8'h07;
   localparam logic [7:0] OP_SHR  = 8'h08;
   localparam logic [7:0] OP_MUL  = 8'h09;
   localparam logic [7:0] OP_HALT = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DECODE    = 3'd1,
      ST_EXECUTE   = 3'd2,
      ST_WRITEBACK = 3'd3,
      ST_HALTED    = 3'd4
   } state_t;

endpackage

// File: rtl/instruction_decoder_shift_add_multiplier.sv
// shift_add_multiplier: unsigned width x width multiplier, one multiplier bit
// per cycle. Only built when DECODER_MUL_EN is defined.
// Ports: clk, reset (sync, active-high), start (load operands, also retires
//        bit 0), a/b operands, busy (iterating), done (one-cycle pulse after
//        the last bit), product (2*width, held until the next start).
`ifdef DECODER_MUL_EN
module shift_add_multiplier #(
   parameter int unsigned width = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [width-1:0]     a,
   input  logic [width-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*width-1:0]   product
);

   localparam int unsigned CNT_W = $clog2(width) + 1;

   logic [2*width-1:0] mcand;
   logic [width-1:0]   mplier;
   logic [CNT_W-1:0]   count;

   // The start edge already accumulates bit 0, so a full product takes
   // exactly width edges from start.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         done    <= 1'b0;
         product <= '0;
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            product <= b[0] ? (2*width)'(a) : '0;
            mcand   <= (2*width)'(a) << 1;
            mplier  <= b >> 1;
            count   <= CNT_W'(1);
            busy    <= 1'b1;
         end else if (busy) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_W'(1);
            if (count == CNT_W'(width - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule
`endif

// File: rtl/instruction_decoder.sv
// instruction_decoder: accepts one instruction word per IDLE visit and runs
// it through DECODE / EXECUTE / WRITEBACK against an accumulator.
// Ports: clk, reset (sync, active-high), start_from_state_machine /
//        data_from_state_machine (instruction handshake in),
//        ready_for_state_machine (high in IDLE), acc, zero_flag, carry_flag,
//        done (retire pulse), illegal_opcode (sticky), halted.
// Parameters: byte_w (opcode/operand/acc width), width_in (instruction width).
// Build option: DECODER_MUL_EN adds the iterative MUL opcode (0x09).
module instruction_decoder
   import decoder_pkg::*;
#(
   parameter int unsigned byte_w   = DEC_BYTE,
   parameter int unsigned width_in = 2 * byte_w
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start_from_state_machine,
   input  logic [width_in-1:0] data_from_state_machine,
   output logic                ready_for_state_machine,
   output logic [byte_w-1:0]   acc,
   output logic                zero_flag,
   output logic                carry_flag,
   output logic                done,
   output logic                illegal_opcode,
   output logic                halted
);

   state_t            state;
   state_t            next_state;
   logic [byte_w-1:0] opcode;
   logic [byte_w-1:0] operand;
   logic              capture_c;

   logic [byte_w-1:0] acc_n;
   logic              zero_n;
   logic              carry_n;
   logic              done_n;
   logic              illegal_n;
   logic [byte_w-1:0] res;
   logic [byte_w:0]   sum;
   logic              alu;

`ifdef DECODER_MUL_EN
   logic                mul_start_c;
   logic                mul_busy;
   logic                mul_done;
   logic [2*byte_w-1:0] mul_product;

   shift_add_multiplier #(.width(byte_w)) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start_c),
      .a       (acc),
      .b       (operand),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   // Next-state logic
   always_comb begin
      next_state = state;
      capture_c  = 1'b0;
`ifdef DECODER_MUL_EN
      mul_start_c = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (start_from_state_machine) begin
               capture_c  = 1'b1;
               next_state = ST_DECODE;
            end
         end
         ST_DECODE: begin
            next_state = ST_EXECUTE;
`ifdef DECODER_MUL_EN
            // Launch on the DECODE->EXECUTE edge so EXECUTE spans the iterations
            mul_start_c = (opcode == byte_w'(OP_MUL));
`endif
         end
         ST_EXECUTE: begin
`ifdef DECODER_MUL_EN
            if ((opcode != byte_w'(OP_MUL)) || (mul_done && !mul_busy)) begin
               next_state = ST_WRITEBACK;
            end
`else
            next_state = ST_WRITEBACK;
`endif
         end
         ST_WRITEBACK: begin
            next_state = (opcode == byte_w'(OP_HALT)) ? ST_HALTED : ST_IDLE;
         end
         ST_HALTED: next_state = ST_HALTED;
         default:   next_state = ST_IDLE;
      endcase
   end

   // Writeback: accumulator and flag update for the retiring instruction
   always_comb begin
      acc_n     = acc;
      zero_n    = zero_flag;
      carry_n   = carry_flag;
      illegal_n = illegal_opcode;
      done_n    = 1'b0;
      res       = acc;
      sum       = '0;
      alu       = 1'b0;
      if (state == ST_WRITEBACK) begin
         done_n = 1'b1;
         case (opcode)
            byte_w'(OP_NOP), byte_w'(OP_HALT): begin
            end
            byte_w'(OP_LDI): begin
               res = operand; carry_n = 1'b0; alu = 1'b1;
            end
            byte_w'(OP_ADD): begin
               sum     = {1'b0, acc} + {1'b0, operand};
               res     = sum[byte_w-1:0];
               carry_n = sum[byte_w];
               alu     = 1'b1;
            end
            byte_w'(OP_SUB): begin
               res = acc - operand; carry_n = (acc < operand); alu = 1'b1;
            end
            byte_w'(OP_AND): begin
               res = acc & operand; carry_n = 1'b0; alu = 1'b1;
            end
            byte_w'(OP_OR): begin
               res = acc | operand; carry_n = 1'b0; alu = 1'b1;
            end
            byte_w'(OP_XOR): begin
               res = acc ^ operand; carry_n = 1'b0; alu = 1'b1;
            end
            byte_w'(OP_SHL): begin
               res = acc << operand[2:0]; carry_n = 1'b0; alu = 1'b1;
            end
            byte_w'(OP_SHR): begin
               res = acc >> operand[2:0]; carry_n = 1'b0; alu = 1'b1;
            end
`ifdef DECODER_MUL_EN
            byte_w'(OP_MUL): begin
               res     = mul_product[byte_w-1:0];
               carry_n = |mul_product[2*byte_w-1:byte_w];
               alu     = 1'b1;
            end
`endif
            default: illegal_n = 1'b1;
         endcase
         if (alu) begin
            acc_n  = res;
            zero_n = (res == '0);
         end
      end
   end

   // State register, instruction capture and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state                   <= ST_IDLE;
         ready_for_state_machine <= 1'b1;
         halted                  <= 1'b0;
         acc                     <= '0;
         zero_flag               <= 1'b1;
         carry_flag              <= 1'b0;
         done                    <= 1'b0;
         illegal_opcode          <= 1'b0;
         opcode                  <= '0;
         operand                 <= '0;
      end else begin
         state                   <= next_state;
         ready_for_state_machine <= (next_state == ST_IDLE);
         halted                  <= (next_state == ST_HALTED);
         acc                     <= acc_n;
         zero_flag               <= zero_n;
         carry_flag              <= carry_n;
         done                    <= done_n;
         illegal_opcode          <= illegal_n;
         if (capture_c) begin
            opcode  <= data_from_state_machine[2*byte_w-1 -: byte_w];
            operand <= data_from_state_machine[byte_w-1:0];
         end
      end
   end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench for instruction_decoder: directed vector table,
// hand-written multi-cycle sequences, and random instructions checked
// against a behavioural accumulator model.
module tb_instruction_decoder;

`ifdef DECODER_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [15:0] data;
   logic        ready;
   logic [7:0]  acc;
   logic        zero_flag;
   logic        carry_flag;
   logic        done;
   logic        illegal_opcode;
   logic        halted;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int m_acc;
   bit m_zero, m_carry, m_illegal;

   instruction_decoder dut (
      .clk                      (clk),
      .reset                    (reset),
      .start_from_state_machine (start),
      .data_from_state_machine  (data),
      .ready_for_state_machine  (ready),
      .acc                      (acc),
      .zero_flag                (zero_flag),
      .carry_flag               (carry_flag),
      .done                     (done),
      .illegal_opcode           (illegal_opcode),
      .halted                   (halted)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   typedef struct {
      logic [15:0] word;
      logic [7:0]  exp_acc;
      bit          exp_zero;
      bit          exp_carry;
      bit          exp_illegal;
   } vec_t;

   vec_t vecs[17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      tick();
      reset = 1'b0;
      m_acc = 0; m_zero = 1'b1; m_carry = 1'b0; m_illegal = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},   32'(ready), 1);
      check({tag, "_acc"},     32'(acc), 0);
      check({tag, "_zero"},    32'(zero_flag), 1);
      check({tag, "_carry"},   32'(carry_flag), 0);
      check({tag, "_done"},    32'(done), 0);
      check({tag, "_illegal"}, 32'(illegal_opcode), 0);
      check({tag, "_halted"},  32'(halted), 0);
   endtask

   // Behavioural accumulator semantics
   task automatic model_exec(input int op, input int opnd);
      int p;
      bit alu;
      alu = 1'b1;
      case (op)
         1: begin m_acc = opnd; m_carry = 0; end
         2: begin p = m_acc + opnd; m_carry = (p > 255); m_acc = p % 256; end
         3: begin m_carry = (m_acc < opnd); m_acc = (m_acc - opnd + 256) % 256; end
         4: begin m_acc = m_acc & opnd; m_carry = 0; end
         5: begin m_acc = m_acc | opnd; m_carry = 0; end
         6: begin m_acc = m_acc ^ opnd; m_carry = 0; end
         7: begin m_acc = (m_acc * (1 << (opnd % 8))) % 256; m_carry = 0; end
         8: begin m_acc = m_acc / (1 << (opnd % 8)); m_carry = 0; end
         9: begin
            if (MUL_EN) begin
               p = m_acc * opnd; m_acc = p % 256; m_carry = (p >= 256);
            end else begin
               m_illegal = 1; alu = 0;
            end
         end
         0, 255: alu = 0;
         default: begin m_illegal = 1; alu = 0; end
      endcase
      if (alu) m_zero = (m_acc == 0);
   endtask

   function automatic int exp_latency(input int op);
      return (MUL_EN && op == 9) ? 10 : 3;
   endfunction

   // Waits for done; latency counts edges after the capture edge
   task automatic wait_done(output int lat);
      lat = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         lat++;
         if (done) break;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL done_timeout actual=0 required=1");
      end
   endtask

   task automatic issue(input logic [15:0] word, output int lat);
      for (int i = 0; i < 20 && !ready; i++) tick();
      check("issue_ready", 32'(ready), 1);
      start = 1'b1;
      data  = word;
      tick();
      start = 1'b0;
      data  = $urandom();
      wait_done(lat);
   endtask

   initial begin
      int lat;
      int op, opnd;
      reset = 1'b0;
      start = 1'b0;
      data  = '0;

      vecs[0]  = '{16'h0105, 8'h05, 0, 0, 0};
      vecs[1]  = '{16'h01F0, 8'hF0, 0, 0, 0};
      vecs[2]  = '{16'h0220, 8'h10, 0, 1, 0};
      vecs[3]  = '{16'h0311, 8'hFF, 0, 1, 0};
      vecs[4]  = '{16'h03FF, 8'h00, 1, 0, 0};
      vecs[5]  = '{16'h01AA, 8'hAA, 0, 0, 0};
      vecs[6]  = '{16'h040F, 8'h0A, 0, 0, 0};
      vecs[7]  = '{16'h0550, 8'h5A, 0, 0, 0};
      vecs[8]  = '{16'h065A, 8'h00, 1, 0, 0};
      vecs[9]  = '{16'h0181, 8'h81, 0, 0, 0};
      vecs[10] = '{16'h0280, 8'h01, 0, 1, 0};
      vecs[11] = '{16'h0000, 8'h01, 0, 1, 0};
      vecs[12] = '{16'h0702, 8'h04, 0, 0, 0};
      vecs[13] = '{16'h0801, 8'h02, 0, 0, 0};
      vecs[14] = '{16'h3C55, 8'h02, 0, 0, 1};
      vecs[15] = '{16'h0101, 8'h01, 0, 0, 1};
      vecs[16] = '{16'h0800, 8'h01, 0, 0, 1};

      do_reset();
      check_reset_values("rst");

      // Directed vector table
      for (int i = 0; i < 17; i++) begin
         issue(vecs[i].word, lat);
         check($sformatf("vec%0d_latency", i), 32'(lat), 3);
         check($sformatf("vec%0d_acc", i),     32'(acc), 32'(vecs[i].exp_acc));
         check($sformatf("vec%0d_zero", i),    32'(zero_flag), 32'(vecs[i].exp_zero));
         check($sformatf("vec%0d_carry", i),   32'(carry_flag), 32'(vecs[i].exp_carry));
         check($sformatf("vec%0d_illegal", i), 32'(illegal_opcode), 32'(vecs[i].exp_illegal));
         check($sformatf("vec%0d_ready", i),   32'(ready), 1);
         if (i == 0) begin
            tick();
            check("done_one_pulse", 32'(done), 0);
         end
      end

      // Start held high: one capture per IDLE visit, ready low while busy
      do_reset();
      start = 1'b1;
      data  = 16'h0111;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("hold_ready_low", 32'(ready), 0);
         data = 16'h0122 + 16'(i * 17);
         tick();
      end
      check("hold_done", 32'(done), 1);
      check("hold_ready", 32'(ready), 1);
      check("hold_acc_first", 32'(acc), 32'h11);
      data = 16'h0144;
      tick();
      start = 1'b0;
      wait_done(lat);
      check("hold_latency2", 32'(lat), 3);
      check("hold_acc_second", 32'(acc), 32'h44);

      // HALT then ignored start, then reset recovery
      do_reset();
      issue(16'h0133, lat);
      issue(16'hFF00, lat);
      check("halt_latency", 32'(lat), 3);
      check("halt_halted", 32'(halted), 1);
      check("halt_ready", 32'(ready), 0);
      start = 1'b1;
      data  = 16'h0107;
      for (int i = 0; i < 6; i++) tick();
      check("halt_acc_kept", 32'(acc), 32'h33);
      check("halt_still", 32'(halted), 1);
      check("halt_ready_low", 32'(ready), 0);
      check("halt_no_done", 32'(done), 0);
      do_reset();
      check_reset_values("halt_rst");

      // Reset in the middle of a single-cycle instruction
      issue(16'h0155, lat);
      start = 1'b1; data = 16'h01AA;
      tick();
      start = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("mid_rst");
      tick();
      check("mid_rst_no_done", 32'(done), 0);

`ifdef DECODER_MUL_EN
      do_reset();
      issue(16'h0110, lat);
      issue(16'h0911, lat);
      check("mul_latency", 32'(lat), 10);
      check("mul_acc", 32'(acc), 32'h10);
      check("mul_carry", 32'(carry_flag), 1);
      check("mul_zero", 32'(zero_flag), 0);
      // Reset while the multiplier is iterating
      start = 1'b1; data = 16'h0903;
      tick();
      start = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_reset_values("mul_rst");
      for (int i = 0; i < 8; i++) tick();
      check("mul_rst_acc_stays", 32'(acc), 0);
      check("mul_rst_no_done", 32'(done), 0);
`else
      do_reset();
      issue(16'h0122, lat);
      issue(16'h0911, lat);
      check("nomul_latency", 32'(lat), 3);
      check("nomul_illegal", 32'(illegal_opcode), 1);
      check("nomul_acc", 32'(acc), 32'h22);
`endif

      // Random instructions against the model
      do_reset();
      for (int n = 0; n < 120; n++) begin
         op = $urandom_range(0, 10);
         if (op == 10) op = $urandom_range(10, 254);
         opnd = $urandom_range(0, 255);
         if ((n % 40) == 39) do_reset();
         model_exec(op, opnd);
         issue({8'(op), 8'(opnd)}, lat);
         check("rnd_latency", 32'(lat), 32'(exp_latency(op)));
         check("rnd_acc",     32'(acc), 32'(m_acc));
         check("rnd_zero",    32'(zero_flag), 32'(m_zero));
         check("rnd_carry",   32'(carry_flag), 32'(m_carry));
         check("rnd_illegal", 32'(illegal_opcode), 32'(m_illegal));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instruction_decoder.md
INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

Interface
REQ-001 Parameter byte, default 8, width of opcode, operand and accumulator.
REQ-002 Parameter width_in, default 2*byte, width of the instruction word from the upstream state machine.
REQ-003 Port clk, input, 1, single clock; all state changes on posedge clk.
REQ-004 Port reset, input, 1, synchronous, active-high reset.
REQ-005 Port start_from_state_machine, input, 1, instruction valid strobe from the upstream state machine.
REQ-006 Port data_from_state_machine, input, width_in, instruction word: [15:8] opcode, [7:0] operand.
REQ-007 Port ready_for_state_machine, output, 1, high when the block can accept an instruction.
REQ-008 Port acc, output, byte, accumulator value.
REQ-009 Port zero_flag, output, 1, set when acc equals 0 after the last executed ALU op.
REQ-010 Port carry_flag, output, 1, carry/borrow/overflow of the last executed op.
REQ-011 Port done, output, 1, one-cycle pulse when an instruction retires.
REQ-012 Port illegal_opcode, output, 1, sticky flag for an unknown opcode.
REQ-013 Port halted, output, 1, high after HALT retires.

Function
REQ-014 States: IDLE, DECODE, EXECUTE, WRITEBACK, HALTED; encoding 3 bits.
REQ-015 ready_for_state_machine is high only in IDLE.
REQ-016 Instruction is captured on the edge where start_from_state_machine && ready_for_state_machine; start is ignored in every other state.
REQ-017 IDLE->DECODE on capture; DECODE->EXECUTE; EXECUTE->WRITEBACK when the op completes; WRITEBACK->IDLE, or ->HALTED for HALT.
REQ-018 Single-cycle ops: capture at edge E0; acc, flags and done update at edge E3; done and ready are both high in the cycle after E3.
REQ-019 Opcodes: 0x00 NOP; 0x01 LDI acc=operand; 0x02 ADD; 0x03 SUB; 0x04 AND; 0x05 OR; 0x06 XOR; 0x07 SHL by operand[2:0]; 0x08 SHR by operand[2:0]; 0x09 MUL (see REQ-029); 0xFF HALT.
REQ-020 ADD: carry = bit 8 of the 9-bit sum. SUB: carry = borrow (acc < operand). Results wrap modulo 2^byte.
REQ-021 AND/OR/XOR/SHL/SHR/LDI clear carry; shifts are logical; zero_flag updates on all ALU ops including LDI.
REQ-022 NOP and HALT leave acc and flags unchanged and still pulse done.
REQ-023 An unknown opcode leaves acc and flags unchanged, sets illegal_opcode (cleared only by reset), and pulses done.
REQ-024 HALTED: ready stays low, halted stays high, and all starts are ignored until reset.

Reset
REQ-025 reset has priority over every other event on the same edge; it aborts any in-flight instruction, including a MUL mid-iteration.
REQ-026 After reset: state IDLE, ready_for_state_machine=1, acc=0, zero_flag=1, carry_flag=0, done=0, illegal_opcode=0, halted=0.

Configuration
REQ-027 Macro DECODER_MUL_EN compiles in opcode 0x09 MUL.
REQ-028 Without DECODER_MUL_EN, 0x09 is handled as illegal per REQ-023 and no multiplier logic is present.
REQ-029 With DECODER_MUL_EN, MUL computes acc*operand in EXECUTE over exactly byte (8) cycles of shift-add:
- acc = low byte of the product.
- carry_flag = 1 if the high byte is nonzero.
- done is high in the cycle after edge E0+10.

Structure
REQ-030 Shared package decoder_pkg holds the opcode constants, the state encoding and the byte/width constants.
REQ-031 One sub-module, shift_add_multiplier (start/busy/done handshake, one bit per cycle), is instantiated only under DECODER_MUL_EN.

Verification
REQ-032 Reset, then LDI 0x05 -> acc=0x05, zero=0, carry=0, done pulses in the 4th cycle after capture.
REQ-033 LDI 0xF0, ADD 0x20 -> acc=0x10, carry=1; SUB 0x11 -> acc=0xFF, carry=1; SUB 0xFF -> acc=0x00, zero=1, carry=0.
REQ-034 Hold start high continuously with different words -> only one word is captured per IDLE visit; ready is low from DECODE through WRITEBACK.
REQ-035 Opcode 0x3C -> illegal_opcode=1, acc unchanged; a following LDI 0x01 executes normally and illegal_opcode stays 1.
REQ-036 HALT, then start with LDI 0x07 -> halted=1, ready=0, acc unchanged; after reset, ready=1 and halted=0.
REQ-037 With DECODER_MUL_EN: LDI 0x10, MUL 0x11 -> acc=0x10, carry=1. Without the macro, 0x09 -> illegal. Reset asserted mid-MUL -> REQ-026 values on the next cycle.
